// File: rtl/rsa_avm_stream_bridge.sv
// rsa_avm_stream_bridge: Avalon-MM master that polls a UART for key/ciphertext bytes,
// drives an external RSA core and streams the truncated result back out, MSB-first.
module rsa_avm_stream_bridge #(
    parameter int RSA_BITS       = 256,
    parameter int OUT_SKIP_BYTES = 1,
    parameter int CNT_W          = 16
) (
    input  logic                avm_clk,
    input  logic                avm_rst_n,
    output logic [4:0]          avm_address,
    output logic                avm_read,
    input  logic [31:0]         avm_readdata,
    output logic                avm_write,
    output logic [31:0]         avm_writedata,
    input  logic                avm_waitrequest,
    input  logic                i_key_reload,
    output logic                o_core_start,
    output logic [RSA_BITS-1:0] o_core_a,
    output logic [RSA_BITS-1:0] o_core_d,
    output logic [RSA_BITS-1:0] o_core_n,
    input  logic [RSA_BITS-1:0] i_core_result,
    input  logic                i_core_finished,
    output logic [2:0]          o_phase,
    output logic [CNT_W-1:0]    o_block_count
);
    localparam int BYTES = RSA_BITS / 8;
    localparam int CW    = $clog2(BYTES) + 1;

    typedef enum logic [2:0] {LOAD_N, LOAD_D, LOAD_A, CORE, SEND} phase_t;
    typedef enum logic [1:0] {POLL, XFER, GAP} bus_t;

    phase_t              phase_q, phase_d;
    bus_t                bus_q, bus_d;
    logic [RSA_BITS-1:0] n_q, n_d, d_q, d_d, a_q, a_d, res_q, res_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]    blk_q, blk_d;
    logic [4:0]          addr_q, addr_d;
    logic [7:0]          wbyte_q, wbyte_d;
    logic                go_q, go_d, reload_q, reload_d, pend_q, pend_d;
    logic                start_q, start_d, read_q, read_d, write_q, write_d;
    logic                done, send, last_rx, last_tx, reload_now, unused_ok;

    assign unused_ok  = ^avm_readdata[31:8];
    assign done       = (read_q | write_q) & ~avm_waitrequest;
    assign send       = phase_q == SEND;
    assign last_rx    = cnt_q == CW'(BYTES - 1);
    assign last_tx    = cnt_q == CW'(BYTES - OUT_SKIP_BYTES - 1);
    assign reload_now = reload_q | i_key_reload;

    always_comb begin
        phase_d  = phase_q;
        bus_d    = bus_q;
        n_d      = n_q;
        d_d      = d_q;
        a_d      = a_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        blk_d    = blk_q;
        addr_d   = addr_q;
        wbyte_d  = wbyte_q;
        go_d     = go_q;
        reload_d = reload_now;
        pend_d   = 1'b0;
        start_d  = pend_q;
        read_d   = read_q;
        write_d  = write_q;
        case (bus_q)
            GAP: if (phase_q != CORE) begin
                bus_d   = go_q ? XFER : POLL;
                go_d    = 1'b0;
                read_d  = !(go_q && send);
                write_d = go_q && send;
                addr_d  = !go_q ? 5'd8 : send ? 5'd4 : 5'd0;
                wbyte_d = (go_q && send) ? res_q[RSA_BITS-1 -: 8] : wbyte_q;
            end
            POLL: if (done) begin
                bus_d  = GAP;
                read_d = 1'b0;
                go_d   = send ? avm_readdata[6] : avm_readdata[7];
            end
            default: if (done) begin
                bus_d   = GAP;
                read_d  = 1'b0;
                write_d = 1'b0;
                cnt_d   = cnt_q + 1'b1;
                if (send) begin
                    res_d = res_q << 8;
                    if (last_tx) begin
                        cnt_d    = '0;
                        blk_d    = blk_q + 1'b1;
                        reload_d = 1'b0;
                        phase_d  = reload_now ? LOAD_N : LOAD_A;
                    end
                end else begin
                    n_d = (phase_q == LOAD_N) ? {n_q[RSA_BITS-9:0], avm_readdata[7:0]} : n_q;
                    d_d = (phase_q == LOAD_D) ? {d_q[RSA_BITS-9:0], avm_readdata[7:0]} : d_q;
                    a_d = (phase_q == LOAD_A) ? {a_q[RSA_BITS-9:0], avm_readdata[7:0]} : a_q;
                    if (last_rx) begin
                        cnt_d   = '0;
                        phase_d = (phase_q == LOAD_N) ? LOAD_D : (phase_q == LOAD_D) ? LOAD_A : CORE;
                        pend_d  = phase_q == LOAD_A;
                    end
                end
            end
        endcase
        if (phase_q == CORE && i_core_finished) begin
            res_d   = i_core_result << (8 * OUT_SKIP_BYTES);
            phase_d = SEND;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge avm_clk) begin
        if (!avm_rst_n) begin
            phase_q  <= LOAD_N;
            bus_q    <= GAP;
            n_q      <= '0;
            d_q      <= '0;
            a_q      <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            blk_q    <= '0;
            addr_q   <= 5'd8;
            wbyte_q  <= '0;
            go_q     <= 1'b0;
            reload_q <= 1'b0;
            pend_q   <= 1'b0;
            start_q  <= 1'b0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            bus_q    <= bus_d;
            n_q      <= n_d;
            d_q      <= d_d;
            a_q      <= a_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            blk_q    <= blk_d;
            addr_q   <= addr_d;
            wbyte_q  <= wbyte_d;
            go_q     <= go_d;
            reload_q <= reload_d;
            pend_q   <= pend_d;
            start_q  <= start_d;
            read_q   <= read_d;
            write_q  <= write_d;
        end
    end

    assign avm_address   = addr_q;
    assign avm_read      = read_q;
    assign avm_write     = write_q;
    assign avm_writedata = {24'b0, wbyte_q};
    assign o_core_start  = start_q;
    assign o_core_a      = a_q;
    assign o_core_d      = d_q;
    assign o_core_n      = n_q;
    assign o_phase       = phase_q;
    assign o_block_count = blk_q;
endmodule

// File: tb/tb_rsa_avm_stream_bridge.sv
// tb_rsa_avm_stream_bridge: directed bench with a UART slave model (random stalls and
// RX/TX ready delays) and a hand-driven core-finished pulse.
module tb_rsa_avm_stream_bridge;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  avm_address;
    logic        avm_read, avm_write;
    logic [31:0] avm_readdata = '0;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest = 1'b0;
    logic        key_reload = 1'b0;
    logic        core_start;
    logic [31:0] core_a, core_d, core_n;
    logic [31:0] core_result = '0;
    logic        core_finished = 1'b0;
    logic [2:0]  phase;
    logic [15:0] block_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] rx_q[$];
    logic [7:0] tx_log[$];
    int  rx_dly = 0, tx_dly = 0, wcnt = 0, force_wait = 0;
    bit  busy = 0, last_status = 0, last_tx_ok = 0;
    int  starts = 0, start_bad = 0, core_bus = 0, seq_bad = 0;

    always #5 clk = ~clk;

    rsa_avm_stream_bridge #(.RSA_BITS(32), .OUT_SKIP_BYTES(1), .CNT_W(16)) dut (
        .avm_clk(clk), .avm_rst_n(rst_n), .avm_address(avm_address), .avm_read(avm_read),
        .avm_readdata(avm_readdata), .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_waitrequest(avm_waitrequest), .i_key_reload(key_reload), .o_core_start(core_start),
        .o_core_a(core_a), .o_core_d(core_d), .o_core_n(core_n), .i_core_result(core_result),
        .i_core_finished(core_finished), .o_phase(phase), .o_block_count(block_count)
    );

    // UART slave: stall length is drawn once per transaction, then counted down.
    always @(negedge clk) begin
        if (rx_dly > 0) rx_dly--;
        if (tx_dly > 0) tx_dly--;
        if (!(avm_read || avm_write)) begin
            busy = 0;
            wcnt = 0;
        end else if (!busy) begin
            busy = 1;
            if (avm_write && force_wait > 0) begin
                wcnt = force_wait;
                force_wait = 0;
            end else wcnt = $urandom_range(0, 5);
        end else if (wcnt > 0) wcnt--;
        avm_waitrequest = wcnt != 0;
        avm_readdata = '0;
        if (avm_address == 5'd8)
            avm_readdata = {24'b0, rx_q.size() > 0 && rx_dly == 0, tx_dly == 0, 6'b0};
        else if (avm_address == 5'd0 && rx_q.size() > 0)
            avm_readdata = {24'b0, rx_q[0]};
    end

    always @(posedge clk) if (rst_n) begin
        if (core_start) begin
            starts++;
            if (phase != 3'd3) start_bad++;
        end
        if (phase == 3'd3 && (avm_read || avm_write)) core_bus++;
        if ((avm_read || avm_write) && !avm_waitrequest) begin
            if (avm_write) begin
                tx_log.push_back(avm_writedata[7:0]);
                if (!(last_status && last_tx_ok) || avm_address != 5'd4) seq_bad++;
                tx_dly = $urandom_range(0, 5);
            end else if (avm_address == 5'd0) begin
                void'(rx_q.pop_front());
                rx_dly = $urandom_range(0, 5);
            end
            last_status = avm_read && avm_address == 5'd8;
            last_tx_ok = avm_readdata[6];
        end
    end

    task automatic push4(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) rx_q.push_back(w[i*8 +: 8]);
    endtask

    task automatic wait_phase(input logic [2:0] p, output bit ok);
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(posedge clk); #1;
            ok = phase == p;
        end
    endtask

    task automatic wait_rx_empty(output bit ok);
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(posedge clk); #1;
            ok = rx_q.size() == 0;
        end
    endtask

    task automatic finish_core(input logic [31:0] r);
        @(negedge clk);
        core_result = r;
        core_finished = 1'b1;
        @(negedge clk);
        core_finished = 1'b0;
    endtask

    task automatic test_reset;
        bit ok;
        push4(32'h0A0B0C0D);
        rx_q.push_back(8'h00);
        rx_q.push_back(8'h00);
        wait_rx_empty(ok);
        n_cmp++;
        if (!ok || phase !== 3'd1) begin
            n_bad++;
            $display("FAIL reset_setup: phase=%0d ok=%0d, required phase=1", phase, ok);
        end
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({avm_read, avm_write, avm_address, block_count, phase} !== {1'b0, 1'b0, 5'd8, 16'd0, 3'd0}) begin
            n_bad++;
            $display("FAIL reset_state: rd=%b wr=%b addr=%0d blk=%0d ph=%0d, required 0 0 8 0 0",
                     avm_read, avm_write, avm_address, block_count, phase);
        end
        n_cmp++;
        if ({core_n, core_d, core_start} !== 65'd0) begin
            n_bad++;
            $display("FAIL reset_regs: n=%h d=%h start=%b, required all zero", core_n, core_d, core_start);
        end
        @(negedge clk); rst_n = 1'b1;
        rx_q.push_back(8'h0A);
        wait_rx_empty(ok);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (!ok || core_n !== 32'h0000000A || phase !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_next_byte: n=%h ph=%0d, required n=0000000a ph=0", core_n, phase);
        end
    endtask

    task automatic test_load;
        bit ok;
        rx_q.push_back(8'h0B);
        rx_q.push_back(8'h0C);
        rx_q.push_back(8'h0D);
        push4(32'h00000011);
        push4(32'h12345678);
        wait_phase(3'd3, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL load_core_timeout: phase=%0d, required 3", phase);
        end
        n_cmp++;
        if (core_n !== 32'h0A0B0C0D) begin
            n_bad++;
            $display("FAIL load_n: got %h, required 0a0b0c0d", core_n);
        end
        n_cmp++;
        if (core_d !== 32'h00000011) begin
            n_bad++;
            $display("FAIL load_d: got %h, required 00000011", core_d);
        end
        n_cmp++;
        if (core_a !== 32'h12345678) begin
            n_bad++;
            $display("FAIL load_a: got %h, required 12345678", core_a);
        end
        repeat (20) @(posedge clk);
        #1;
        n_cmp++;
        if (starts !== 1 || start_bad !== 0 || core_bus !== 0) begin
            n_bad++;
            $display("FAIL load_start: starts=%0d bad=%0d core_bus=%0d, required 1 0 0", starts, start_bad, core_bus);
        end
    endtask

    task automatic test_send;
        bit ok;
        logic [7:0] exp[3] = '{8'h22, 8'h33, 8'h44};
        tx_log.delete();
        finish_core(32'h11223344);
        wait_phase(3'd2, ok);
        n_cmp++;
        if (!ok || block_count !== 16'd1) begin
            n_bad++;
            $display("FAIL send_end: ph=%0d blk=%0d, required ph=2 blk=1", phase, block_count);
        end
        n_cmp++;
        if (tx_log.size() !== 3 || seq_bad !== 0) begin
            n_bad++;
            $display("FAIL send_count: writes=%0d seq_bad=%0d, required 3 0", tx_log.size(), seq_bad);
        end
        for (int i = 0; i < 3 && i < tx_log.size(); i++) begin
            n_cmp++;
            if (tx_log[i] !== exp[i]) begin
                n_bad++;
                $display("FAIL send_byte%0d: got %h, required %h", i, tx_log[i], exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        push4(32'h00000005);
        wait_phase(3'd3, ok);
        n_cmp++;
        if (!ok || core_a !== 32'h00000005 || core_n !== 32'h0A0B0C0D || core_d !== 32'h00000011) begin
            n_bad++;
            $display("FAIL stream_regs: a=%h n=%h d=%h, required 00000005 0a0b0c0d 00000011", core_a, core_n, core_d);
        end
        tx_log.delete();
        repeat (5) @(posedge clk);
        finish_core(32'h00AABBCC);
        wait_phase(3'd2, ok);
        n_cmp++;
        if (!ok || block_count !== 16'd2 || starts !== 2) begin
            n_bad++;
            $display("FAIL stream_end: blk=%0d starts=%0d, required 2 2", block_count, starts);
        end
        n_cmp++;
        if (tx_log.size() !== 3 || tx_log[0] !== 8'hAA || tx_log[2] !== 8'hCC) begin
            n_bad++;
            $display("FAIL stream_bytes: n=%0d first=%h last=%h, required 3 aa cc", tx_log.size(),
                     tx_log.size() > 0 ? tx_log[0] : 8'h00, tx_log.size() > 2 ? tx_log[2] : 8'h00);
        end
    endtask

    task automatic test_reload_stall;
        bit ok;
        logic [31:0] wd;
        push4(32'h01020304);
        wait_phase(3'd3, ok);
        @(negedge clk); key_reload = 1'b1;
        @(negedge clk); key_reload = 1'b0;
        tx_log.delete();
        force_wait = 10;
        finish_core(32'h99887766);
        ok = 0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(posedge clk); #1;
            ok = avm_write;
        end
        wd = avm_writedata;
        n_cmp++;
        if (!ok || wd !== 32'h00000088) begin
            n_bad++;
            $display("FAIL stall_first_write: seen=%0d wd=%h, required 1 00000088", ok, wd);
        end
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (avm_write !== 1'b1 || avm_address !== 5'd4 || avm_writedata !== wd) begin
                n_bad++;
                $display("FAIL stall_hold%0d: wr=%b addr=%0d wd=%h, required 1 4 %h", i, avm_write, avm_address, avm_writedata, wd);
            end
            @(posedge clk); #1;
        end
        wait_phase(3'd0, ok);
        n_cmp++;
        if (!ok || block_count !== 16'd3 || tx_log.size() !== 3) begin
            n_bad++;
            $display("FAIL reload_end: ph=%0d blk=%0d writes=%0d, required 0 3 3", phase, block_count, tx_log.size());
        end
        n_cmp++;
        if (tx_log.size() == 3 && (tx_log[1] !== 8'h77 || tx_log[2] !== 8'h66)) begin
            n_bad++;
            $display("FAIL reload_bytes: got %h %h, required 77 66", tx_log[1], tx_log[2]);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        test_reset;
        test_load;
        test_send;
        test_back_to_back;
        test_reload_stall;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
